adc_frame_tx: RTL and testbench
===============================

# adc_frame_tx

Transmit-side counterpart of the ADC LVDS capture path. The block accepts sample pairs in the same 32-bit packing that the capture path produces, buffers them, and emits one 35-bit parallel word per clock for a 7:1 output-serializer wrapper driving 2 data lanes per channel plus a frame lane. It serves as an ADC emulator for loopback and bench testing of the capture and bitslip alignment logic. It also sends a training sequence so the receiver can achieve frame lock before live data arrives.

## Interface
- FIFO_DEPTH, 16: input buffer depth in words; power of 2, 4..64.
- TRAIN_FRAMES, 64: number of training frames sent after enable rises; 1..255.
- TRAIN_PATTERN, 14'h3A5C: sample value sent on both channels during training.
- clk  in  1  serializer divided clock; all logic on rising edge.
- reset_n  in  1  reset; synchronous and active-low.
- enable  in  1  level; high = transmit (train then run), low = idle.
- data_in  in  32  [13:0] = channel A sample, [29:16] = channel B sample; [15:14] and [31:30] ignored.
- data_valid  in  1  data_in is valid this cycle.
- data_ready  out  1  buffer can accept; a transfer happens on an edge where data_valid && data_ready.
- serial_word  out  35  parallel word to the serializer, bit mapping below.
- state  out  2  0 = IDLE, 1 = TRAIN, 2 = RUN.
- underflow_count  out  16  count of RUN frames that had no buffered data; saturating.

## Operation
- Bit mapping for k = 0..6:
  - serial_word[5k] = A[13-k]
  - serial_word[5k+1] = A[6-k]
  - serial_word[5k+2] = B[13-k]
  - serial_word[5k+3] = B[6-k]
  - serial_word[5k+4] = F
- F is the frame bit, constant across all 7 positions of one word.
- Frame bit: a phase flag toggles every frame in TRAIN and RUN. The first frame after entering TRAIN has F=1, then 0, 1, and so on. The phase continues across the TRAIN-to-RUN transition without a repeat.
- The receiver treats a constant frame lane (all 0s or all 1s) as aligned. Every TRAIN and RUN word must therefore carry 7 identical frame bits.
- FIFO:
  - FIFO_DEPTH x 28 bits, storing {B, A}.
  - data_ready = !full, registered from the occupancy count.
  - data_ready is low when full, even if a pop occurs in the same cycle.
  - Writes are accepted in all states, including IDLE.
  - The FIFO is cleared only by reset.
- State machine, evaluated each edge after reset:
  - IDLE:
    - serial_word = 0.
    - Phase flag is set so the next frame sends F=1.
    - If enable = 1, go to TRAIN and load the frame counter with TRAIN_FRAMES.
  - TRAIN:
    - Send A = B = TRAIN_PATTERN with the current F.
    - Decrement the counter each frame.
    - After the last training frame, go to RUN.
    - The FIFO is not popped.
  - RUN:
    - If the FIFO is non-empty, pop the head and send it.
    - Otherwise send A = B = 14'h2000 (midscale) and increment underflow_count, which saturates at 16'hFFFF.
  - In any state, enable = 0 sends the block to IDLE at the next edge. The word registered on that edge is 0. A partially counted training sequence is abandoned. Buffered FIFO data is retained.
- While in RUN, simultaneous push and pop leave the occupancy unchanged.
- underflow_count is cleared only by reset.

## Timing
- Reset (reset_n = 0 at an edge):
  - serial_word = 0, state = IDLE, data_ready = 0, underflow_count = 0.
  - FIFO is empty; phase flag points to F=1.
- data_ready rises on the first edge after reset_n goes high.
- serial_word, state and underflow_count are registered outputs.
- Enable to first training word:
  - enable sampled high at edge E0.
  - state = TRAIN after E0.
  - The first training word (F=1) is registered at E1.
- Training length: exactly TRAIN_FRAMES TRAIN words, on edges E1..E(TRAIN_FRAMES).
- The first RUN word is registered on the next edge.
- Latency in RUN with an empty FIFO:
  - Word written at edge W.
  - It appears on serial_word after edge W+1.
  - The RUN word registered at edge W itself is midscale/underflow.
- Throughput: one word per clock; sustained data_valid = 1 never underflows.
- Full boundary:
  - After the FIFO_DEPTH-th write with no pops, data_ready = 0 from the next cycle.
  - data_ready returns to 1 one cycle after the first pop.
- Reset mid-RUN: all outputs return to reset values at that edge; buffered data is discarded.

## Test plan
- Reset, then enable held high with TRAIN_FRAMES=4 and no data:
  - Exactly 4 words carrying A = B = 14'h3A5C, with frame bits 1, 0, 1, 0.
  - Then midscale words with F continuing 1, 0, 1, 0.
  - underflow_count increments by 1 per RUN clock.
- Preload words 32'h1234_0ABC and 32'hC001_3FFF in IDLE, then enable:
  - After training, the two RUN words decode through the inverse mapping to A=14'h0ABC, B=14'h1234, then A=14'h3FFF, B=14'h0001 (upper bits dropped).
  - Then underflow begins.
- With enable low, push 16 words:
  - data_ready is low after the 16th push.
  - A 17th data_valid is not accepted.
  - In RUN, data_ready returns to 1 one cycle after the first pop.
- Drop enable mid-training at frame 2:
  - serial_word = 0 on the next edge and state = IDLE.
  - Re-enabling restarts a full training sequence beginning with F=1.
- Loop serial_word through a 7:1 serializer into the capture path:
  - The receiver asserts its synchronized flag within training.
  - RUN samples match the input stream exactly in order.
- Force 70000 underflow frames: underflow_count holds at 16'hFFFF.

Source files
------------

// File: rtl/adc_frame_tx.sv
// ADC emulator: buffers packed sample pairs and emits 7:1 serializer words,
// preceded by a training run so the capture side can find frame lock.
module adc_frame_tx #(
  parameter int          FIFO_DEPTH    = 16,
  parameter int          TRAIN_FRAMES  = 64,
  parameter logic [13:0] TRAIN_PATTERN = 14'h3A5C
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [34:0] serial_word,
  output logic [1:0]  state,
  output logic [15:0] underflow_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [13:0]   MIDSCALE = 14'h2000;
  localparam logic [7:0]    TRAIN_C  = 8'(TRAIN_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAIN = 2'd1,
    S_RUN   = 2'd2
  } st_e;

  // MSB-first per lane; lane 4 carries the frame flag
  function automatic logic [34:0] pack_word(
    input logic [13:0] a,
    input logic [13:0] b,
    input logic        f
  );
    logic [34:0] w;
    w = '0;
    for (int k = 0; k < 7; k++) begin
      w[5*k]   = a[13-k];
      w[5*k+1] = a[6-k];
      w[5*k+2] = b[13-k];
      w[5*k+3] = b[6-k];
      w[5*k+4] = f;
    end
    return w;
  endfunction

  logic [27:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q;
  logic          push, pop, empty;
  logic [27:0]   head;

  st_e           state_q, state_d;
  logic [7:0]    frames_q, frames_d;
  logic          phase_q, phase_d;
  logic [34:0]   word_q, word_d;
  logic [15:0]   uf_q, uf_d;
  logic          uf_inc;

  logic          unused_bits;
  assign unused_bits = ^{data_in[31:30], data_in[15:14]};

  assign push  = data_valid && rdy_q;
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {data_in[29:16], data_in[13:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_TRAIN;
        S_TRAIN: if (frames_q == 8'd1) state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    word_d   = '0;
    phase_d  = phase_q;
    frames_d = frames_q;
    pop      = 1'b0;
    uf_inc   = 1'b0;
    if (!enable) begin
      phase_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          phase_d  = 1'b1;
          frames_d = TRAIN_C;
        end
        S_TRAIN: begin
          word_d   = pack_word(TRAIN_PATTERN, TRAIN_PATTERN, phase_q);
          phase_d  = ~phase_q;
          frames_d = frames_q - 8'd1;
        end
        S_RUN: begin
          phase_d = ~phase_q;
          if (!empty) begin
            pop    = 1'b1;
            word_d = pack_word(head[13:0], head[27:14], phase_q);
          end else begin
            uf_inc = 1'b1;
            word_d = pack_word(MIDSCALE, MIDSCALE, phase_q);
          end
        end
        default: phase_d = 1'b1;
      endcase
    end
  end

  assign uf_d = (uf_inc && uf_q != 16'hFFFF) ? uf_q + 16'd1 : uf_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_q   <= '0;
      phase_q  <= 1'b1;
      frames_q <= '0;
      uf_q     <= '0;
    end else begin
      word_q   <= word_d;
      phase_q  <= phase_d;
      frames_q <= frames_d;
      uf_q     <= uf_d;
    end
  end

  assign data_ready      = rdy_q;
  assign serial_word     = word_q;
  assign state           = state_q;
  assign underflow_count = uf_q;

endmodule

// File: tb/tb_adc_frame_tx.sv
// Scoreboard bench for adc_frame_tx: stimulus queues expected frames,
// a negedge monitor decodes serial_word and compares.
module tb_adc_frame_tx;

  localparam logic [13:0] TP  = 14'h3A5C;
  localparam logic [13:0] MID = 14'h2000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [34:0] serial_word;
  logic [1:0]  state;
  logic [15:0] underflow_count;

  always #5 clk = ~clk;

  adc_frame_tx #(
    .FIFO_DEPTH   (16),
    .TRAIN_FRAMES (4),
    .TRAIN_PATTERN(TP)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .serial_word    (serial_word),
    .state          (state),
    .underflow_count(underflow_count)
  );

  typedef struct packed {
    logic [13:0] a;
    logic [13:0] b;
    logic        f;
  } exp_t;

  exp_t        sbq [$];
  int          checks = 0;
  int          errors = 0;
  int          exp_uf = 0;
  bit          mon_on = 1'b0;
  logic        exp_f  = 1'b1;
  logic [1:0]  prev_st = 2'd0;
  logic [13:0] da, db;
  logic [6:0]  dfb;
  exp_t        e;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // a word is live when the block was transmitting before and after the edge
  always @(negedge clk) begin
    if (mon_on && prev_st != 2'd0 && state != 2'd0) begin
      for (int k = 0; k < 7; k++) begin
        da[13-k] = serial_word[5*k];
        da[6-k]  = serial_word[5*k+1];
        db[13-k] = serial_word[5*k+2];
        db[6-k]  = serial_word[5*k+3];
        dfb[k]   = serial_word[5*k+4];
      end
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h required=none", serial_word);
      end else begin
        e = sbq.pop_front();
        check("word_a", 64'(da), 64'(e.a));
        check("word_b", 64'(db), 64'(e.b));
        check("frame_lane", 64'(dfb), 64'({7{e.f}}));
      end
    end
    prev_st = state;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_train(input int n);
    for (int i = 0; i < n; i++) begin
      sbq.push_back('{TP, TP, exp_f});
      exp_f = ~exp_f;
    end
  endtask

  task automatic exp_data(input logic [13:0] a, input logic [13:0] b);
    sbq.push_back('{a, b, exp_f});
    exp_f = ~exp_f;
  endtask

  task automatic exp_mid(input int n);
    for (int i = 0; i < n; i++) begin
      sbq.push_back('{MID, MID, exp_f});
      exp_f = ~exp_f;
    end
    exp_uf += n;
  endtask

  task automatic check_idle(input string name);
    check({name, "_state"}, 64'(state), 64'd0);
    check({name, "_word"}, 64'(serial_word), 64'd0);
    exp_f = 1'b1;
  endtask

  // enable held for the enable edge, 4 training edges and r RUN edges
  task automatic run_enabled(input int r, input string name);
    enable = 1'b1;
    repeat (5 + r) tick();
    enable = 1'b0;
    tick();
    check_idle(name);
    check({name, "_uf"}, 64'(underflow_count), 64'(exp_uf));
    check({name, "_drain"}, 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) tick();
    check("rst_word", 64'(serial_word), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_ready", 64'(data_ready), 64'd0);
    check("rst_uf", 64'(underflow_count), 64'd0);
    reset_n = 1'b1;
    tick();
    check("ready_after_rst", 64'(data_ready), 64'd1);
    mon_on = 1'b1;

    exp_train(4);
    exp_mid(6);
    run_enabled(6, "t1");

    data_valid = 1'b1;
    data_in    = 32'h1234_0ABC;
    tick();
    data_in    = 32'hC001_3FFF;
    tick();
    data_valid = 1'b0;
    exp_train(4);
    exp_data(14'h0ABC, 14'h1234);
    exp_data(14'h3FFF, 14'h0001);
    exp_mid(2);
    run_enabled(4, "t2");

    for (int i = 0; i < 16; i++) begin
      check("ready_pre_push", 64'(data_ready), 64'd1);
      data_valid = 1'b1;
      data_in    = {2'b11, 14'(16'h3FFF - i * 101), 2'b10, 14'(i * 37 + 5)};
      tick();
    end
    check("ready_full", 64'(data_ready), 64'd0);
    data_in = 32'h1555_2AAA;
    repeat (2) tick();
    data_valid = 1'b0;
    check("ready_still_full", 64'(data_ready), 64'd0);
    exp_train(4);
    for (int i = 0; i < 16; i++) begin
      exp_data(14'(i * 37 + 5), 14'(16'h3FFF - i * 101));
    end
    exp_mid(2);
    enable = 1'b1;
    repeat (5) tick();
    check("ready_train_full", 64'(data_ready), 64'd0);
    tick();
    check("ready_after_pop", 64'(data_ready), 64'd1);
    repeat (17) tick();
    enable = 1'b0;
    tick();
    check_idle("t3");
    check("t3_uf", 64'(underflow_count), 64'(exp_uf));
    check("t3_drain", 64'(sbq.size()), 64'd0);

    exp_train(2);
    enable = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    tick();
    check_idle("t4_abort");
    check("t4_abort_drain", 64'(sbq.size()), 64'd0);
    exp_train(4);
    exp_mid(2);
    run_enabled(2, "t4");

    mon_on = 1'b0;
    enable = 1'b1;
    repeat (5 + 70000) tick();
    check("uf_saturate", 64'(underflow_count), 64'hFFFF);
    reset_n = 1'b0;
    tick();
    check("rstrun_word", 64'(serial_word), 64'd0);
    check("rstrun_state", 64'(state), 64'd0);
    check("rstrun_ready", 64'(data_ready), 64'd0);
    check("rstrun_uf", 64'(underflow_count), 64'd0);
    reset_n = 1'b1;
    enable  = 1'b0;
    tick();
    exp_uf = 0;

    data_valid = 1'b1;
    data_in    = 32'h0111_0222;
    repeat (2) tick();
    data_valid = 1'b0;
    reset_n    = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    mon_on = 1'b1;
    exp_f  = 1'b1;
    exp_train(4);
    exp_mid(2);
    run_enabled(2, "t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
